// File: rtl/winograd_input_transform.sv
// Winograd F(4x4,3x3) input transform stage (Itrans).
// Collects a 6x6 tile one row per accepted handshake, then computes
// R = B^T * d * B over two register stages (or passes d through for
// 1x1/6x6 kernels), saturates to OUT_W and emits a one-cycle-valid tile.
//
// Handshake: a row transfers on a rising edge where row_valid_i && row_ready_o.
// row_ready_o is high only in LOAD; the source holds row data/valid until it
// is taken. Tile index and kernel type are captured with row 0 only.
module winograd_input_transform #(
    parameter int PIX_W = 8,
    parameter int OUT_W = 14,
    parameter int IDX_W = 9
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             row_valid_i,
    output logic                             row_ready_o,
    input  logic [5:0][PIX_W-1:0]            row_data_i,
    input  logic [IDX_W-1:0]                 tile_x_i,
    input  logic [IDX_W-1:0]                 tile_y_i,
    input  logic                             size_type_i,
    output logic [5:0][5:0][OUT_W-1:0]       data_tile_o,
    output logic                             data_valid_o,
    output logic [IDX_W-1:0]                 data_x_index_o,
    output logic [IDX_W-1:0]                 data_y_index_o,
    output logic                             sat_o,
    output logic                             busy_o
);

    // Stage-1 width holds |B^T row| sum (10) times a pixel; stage 2 grows by
    // the same factor again, giving the 19-bit result at PIX_W = 8.
    localparam int TW = PIX_W + 5;
    localparam int RW = TW + 6;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_S1   = 2'd1;
    localparam logic [1:0] ST_S2   = 2'd2;

    localparam logic signed [RW-1:0] SAT_MAX = RW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]                  r_state;
    logic [2:0]                  r_row_cnt;
    logic [5:0][5:0][PIX_W-1:0]  r_buf;
    logic                        r_type;
    logic [IDX_W-1:0]            r_x;
    logic [IDX_W-1:0]            r_y;
    logic [5:0][5:0][TW-1:0]     r_t;

    logic                        w_accept;
    logic [5:0][5:0][TW-1:0]     w_t;
    logic [5:0][5:0][OUT_W-1:0]  w_tile;
    logic                        w_sat;

    // One row of B^T applied to a 6-vector, shifts and adds only.
    function automatic logic signed [RW-1:0] bt_row(
        input int i,
        input logic signed [RW-1:0] v0, input logic signed [RW-1:0] v1,
        input logic signed [RW-1:0] v2, input logic signed [RW-1:0] v3,
        input logic signed [RW-1:0] v4, input logic signed [RW-1:0] v5
    );
        logic signed [RW-1:0] res;
        case (i)
            0:       res = (v0 <<< 2) - (v2 <<< 2) - v2 + v4;
            1:       res = v3 + v4 - ((v1 + v2) <<< 2);
            2:       res = ((v1 - v2) <<< 2) - v3 + v4;
            3:       res = ((v3 - v1) <<< 1) - v2 + v4;
            4:       res = ((v1 - v3) <<< 1) - v2 + v4;
            default: res = (v1 <<< 2) - (v3 <<< 2) - v3 + v5;
        endcase
        return res;
    endfunction

    function automatic logic signed [RW-1:0] sx_pix(input logic [PIX_W-1:0] p);
        return RW'($signed(p));
    endfunction

    function automatic logic signed [RW-1:0] sx_t(input logic [TW-1:0] p);
        return RW'($signed(p));
    endfunction

    assign row_ready_o = (r_state == ST_LOAD);
    assign busy_o      = (r_state != ST_LOAD);
    assign w_accept    = row_valid_i && row_ready_o;

    // Stage-1 combinational: T = B^T * d (column by column), or T = d.
    always_comb begin
        w_t = '0;
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 6; c++) begin
                if (r_type)
                    w_t[i][c] = TW'(bt_row(i, sx_pix(r_buf[0][c]), sx_pix(r_buf[1][c]),
                                           sx_pix(r_buf[2][c]), sx_pix(r_buf[3][c]),
                                           sx_pix(r_buf[4][c]), sx_pix(r_buf[5][c])));
                else
                    w_t[i][c] = TW'(sx_pix(r_buf[i][c]));
            end
        end
    end

    // Stage-2 combinational: R = T * B (row by row), then clamp to OUT_W.
    always_comb begin
        logic signed [RW-1:0] w_r;
        w_r    = '0;
        w_tile = '0;
        w_sat  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                if (r_type)
                    w_r = bt_row(j, sx_t(r_t[i][0]), sx_t(r_t[i][1]), sx_t(r_t[i][2]),
                                 sx_t(r_t[i][3]), sx_t(r_t[i][4]), sx_t(r_t[i][5]));
                else
                    w_r = sx_t(r_t[i][j]);
                if (w_r > SAT_MAX) begin
                    w_tile[i][j] = SAT_MAX[OUT_W-1:0];
                    w_sat        = 1'b1;
                end else if (w_r < SAT_MIN) begin
                    w_tile[i][j] = SAT_MIN[OUT_W-1:0];
                    w_sat        = 1'b1;
                end else begin
                    w_tile[i][j] = w_r[OUT_W-1:0];
                end
            end
        end
    end

    // Control FSM and row buffer: fill rows in LOAD, then walk S1 -> S2 -> LOAD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_LOAD;
            r_row_cnt <= 3'd0;
            r_buf     <= '0;
            r_type    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_buf[r_row_cnt] <= row_data_i;
                        if (r_row_cnt == 3'd0) begin
                            r_x    <= tile_x_i;
                            r_y    <= tile_y_i;
                            r_type <= size_type_i;
                        end
                        if (r_row_cnt == 3'd5) begin
                            r_row_cnt <= 3'd0;
                            r_state   <= ST_S1;
                        end else begin
                            r_row_cnt <= r_row_cnt + 3'd1;
                        end
                    end
                end
                ST_S1:   r_state <= ST_S2;
                ST_S2:   r_state <= ST_LOAD;
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    // Stage-1 register, loaded once per tile in S1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_t <= '0;
        else if (r_state == ST_S1)
            r_t <= w_t;
    end

    // Output register: tile is presented for one cycle after S2, zero otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_tile_o    <= '0;
            data_valid_o   <= 1'b0;
            data_x_index_o <= '0;
            data_y_index_o <= '0;
            sat_o          <= 1'b0;
        end else if (r_state == ST_S2) begin
            data_tile_o    <= w_tile;
            data_valid_o   <= 1'b1;
            data_x_index_o <= r_x;
            data_y_index_o <= r_y;
            sat_o          <= w_sat;
        end else begin
            data_tile_o    <= '0;
            data_valid_o   <= 1'b0;
            data_x_index_o <= '0;
            data_y_index_o <= '0;
            sat_o          <= 1'b0;
        end
    end

endmodule
